// File: rtl/exe_stage_module.sv
// Execute stage: operand forwarding, operand-2 generation, ALU, NZCV status and
// the EXE/MEM pipeline register (held while the memory stage stalls).
module exe_stage_module #(
    parameter int REGISTER_LEN    = 32,
    parameter int REG_ADDRESS_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic                       s_in,
    input  logic                       b_in,
    input  logic                       imm,
    input  logic [3:0]                 exe_cmd,
    input  logic [REGISTER_LEN-1:0]    pc_in,
    input  logic [REGISTER_LEN-1:0]    val_Rn,
    input  logic [REGISTER_LEN-1:0]    val_Rm,
    input  logic [11:0]                shift_operand,
    input  logic [23:0]                signed_imm_24,
    input  logic [REG_ADDRESS_LEN-1:0] dest_in,
    input  logic [1:0]                 sel_src1,
    input  logic [1:0]                 sel_src2,
    input  logic [REGISTER_LEN-1:0]    mem_fwd,
    input  logic [REGISTER_LEN-1:0]    wb_fwd,
    output logic                       wb_en_out,
    output logic                       mem_r_en_out,
    output logic                       mem_w_en_out,
    output logic [REGISTER_LEN-1:0]    alu_res_out,
    output logic [REGISTER_LEN-1:0]    val_Rm_out,
    output logic [REG_ADDRESS_LEN-1:0] dest_out,
    output logic [3:0]                 status_out,
    output logic                       branch_taken,
    output logic [REGISTER_LEN-1:0]    branch_address,
    output logic                       wb_en_hazard,
    output logic [REG_ADDRESS_LEN-1:0] dest_hazard
);
    localparam int MSB = REGISTER_LEN - 1;

    logic [MSB:0]              val1, rm_f, val2, res_d;
    logic [REGISTER_LEN:0]     sum;
    logic                      c_d, v_d;
    logic [3:0]                status_q;
    logic [4:0]                sh_amt;
    logic [4:0]                rot_amt;

    function automatic logic [MSB:0] ror_w(input logic [MSB:0] x, input logic [4:0] r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

    always_comb begin
        unique case (sel_src1)
            2'b01:   val1 = mem_fwd;
            2'b10:   val1 = wb_fwd;
            default: val1 = val_Rn;
        endcase
        unique case (sel_src2)
            2'b01:   rm_f = mem_fwd;
            2'b10:   rm_f = wb_fwd;
            default: rm_f = val_Rm;
        endcase
    end

    assign sh_amt  = shift_operand[11:7];
    assign rot_amt = {shift_operand[11:8], 1'b0};

    always_comb begin
        if (mem_r_en_in || mem_w_en_in) begin
            val2 = {{(REGISTER_LEN-12){1'b0}}, shift_operand};
        end else if (imm) begin
            val2 = ror_w({{(REGISTER_LEN-8){1'b0}}, shift_operand[7:0]}, rot_amt);
        end else begin
            unique case (shift_operand[6:5])
                2'b00:   val2 = rm_f << sh_amt;
                2'b01:   val2 = rm_f >> sh_amt;
                2'b10:   val2 = $signed(rm_f) >>> sh_amt;
                default: val2 = ror_w(rm_f, sh_amt);
            endcase
        end
    end

    // Subtraction is done as val1 + ~val2 + carry-in so bit 32 is directly NOT borrow.
    always_comb begin
        sum   = '0;
        res_d = '0;
        c_d   = status_q[1];
        v_d   = status_q[0];
        unique case (exe_cmd)
            4'b0001: res_d = val2;
            4'b1001: res_d = ~val2;
            4'b0010, 4'b0011: begin
                sum   = {1'b0, val1} + {1'b0, val2}
                      + {{REGISTER_LEN{1'b0}}, (exe_cmd[0] & status_q[1])};
                res_d = sum[MSB:0];
                c_d   = sum[REGISTER_LEN];
                v_d   = (val1[MSB] == val2[MSB]) && (res_d[MSB] != val1[MSB]);
            end
            4'b0100, 4'b0101: begin
                sum   = {1'b0, val1} + {1'b0, ~val2}
                      + {{REGISTER_LEN{1'b0}}, (exe_cmd[0] ? status_q[1] : 1'b1)};
                res_d = sum[MSB:0];
                c_d   = sum[REGISTER_LEN];
                v_d   = (val1[MSB] != val2[MSB]) && (res_d[MSB] != val1[MSB]);
            end
            4'b0110: res_d = val1 & val2;
            4'b0111: res_d = val1 | val2;
            4'b1000: res_d = val1 ^ val2;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q     <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
            alu_res_out  <= '0;
            val_Rm_out   <= '0;
            dest_out     <= '0;
        end else if (!freeze) begin
            if (s_in) begin
                status_q <= {res_d[MSB], (res_d == '0), c_d, v_d};
            end
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            mem_w_en_out <= mem_w_en_in;
            alu_res_out  <= res_d;
            val_Rm_out   <= rm_f;
            dest_out     <= dest_in;
        end
    end

    assign status_out     = status_q;
    assign branch_taken   = b_in;
    assign branch_address = pc_in + {{(REGISTER_LEN-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
    assign wb_en_hazard   = wb_en_in;
    assign dest_hazard    = dest_in;
endmodule

// File: tb/tb_exe_stage_module.sv
// Directed-vector bench for exe_stage_module with a queue-based scoreboard.
module tb_exe_stage_module;
    logic        clk = 1'b0;
    logic        rst, freeze, wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, imm;
    logic [3:0]  exe_cmd;
    logic [31:0] pc_in, val_Rn, val_Rm, mem_fwd, wb_fwd;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest_in;
    logic [1:0]  sel_src1, sel_src2;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken, wb_en_hazard;
    logic [31:0] alu_res_out, val_Rm_out, branch_address;
    logic [3:0]  dest_out, status_out, dest_hazard;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       nm;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  st;
        logic [2:0]  ctl;
        logic [3:0]  dst;
    } exp_t;
    exp_t sb[$];

    exe_stage_module dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .s_in(s_in), .b_in(b_in), .imm(imm), .exe_cmd(exe_cmd), .pc_in(pc_in),
        .val_Rn(val_Rn), .val_Rm(val_Rm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest_in(dest_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .alu_res_out(alu_res_out), .val_Rm_out(val_Rm_out), .dest_out(dest_out),
        .status_out(status_out), .branch_taken(branch_taken),
        .branch_address(branch_address), .wb_en_hazard(wb_en_hazard),
        .dest_hazard(dest_hazard)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
        $fatal(1, "timeout");
    end

    // Monitor: the pipeline register presents a new value after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (alu_res_out !== e.alu || val_Rm_out !== e.rm || status_out !== e.st ||
                    {wb_en_out, mem_r_en_out, mem_w_en_out} !== e.ctl || dest_out !== e.dst) begin
                    n_err++;
                    $display("FAIL %s: got alu=%h rm=%h st=%b ctl=%b dst=%h, want alu=%h rm=%h st=%b ctl=%b dst=%h",
                             e.nm, alu_res_out, val_Rm_out, status_out,
                             {wb_en_out, mem_r_en_out, mem_w_en_out}, dest_out,
                             e.alu, e.rm, e.st, e.ctl, e.dst);
                end
            end
        end
    end

    task automatic issue(input string nm, input logic frz, input logic [3:0] cmd,
                         input logic s, input logic im, input logic [2:0] ctl,
                         input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] so,
                         input logic [1:0] s1, input logic [1:0] s2, input logic [3:0] dst,
                         input logic [31:0] e_alu, input logic [31:0] e_rm,
                         input logic [3:0] e_st, input logic [2:0] e_ctl, input logic [3:0] e_dst);
        exp_t e;
        @(negedge clk);
        freeze = frz; exe_cmd = cmd; s_in = s; imm = im;
        {wb_en_in, mem_r_en_in, mem_w_en_in} = ctl;
        val_Rn = rn; val_Rm = rm; shift_operand = so;
        sel_src1 = s1; sel_src2 = s2; dest_in = dst;
        e.nm = nm; e.alu = e_alu; e.rm = e_rm; e.st = e_st; e.ctl = e_ctl; e.dst = e_dst;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string nm);
        n_vec++;
        if ({wb_en_out, mem_r_en_out, mem_w_en_out} !== 3'b000 || alu_res_out !== 32'h0 ||
            val_Rm_out !== 32'h0 || dest_out !== 4'h0 || status_out !== 4'h0) begin
            n_err++;
            $display("FAIL %s: got alu=%h rm=%h st=%b ctl=%b dst=%h, want all zero", nm,
                     alu_res_out, val_Rm_out, status_out,
                     {wb_en_out, mem_r_en_out, mem_w_en_out}, dest_out);
        end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        s_in = 1'b0; b_in = 1'b0; imm = 1'b0; exe_cmd = 4'h0; pc_in = 32'h0;
        val_Rn = 32'h0; val_Rm = 32'h0; shift_operand = 12'h0; signed_imm_24 = 24'h0;
        dest_in = 4'h0; sel_src1 = 2'b00; sel_src2 = 2'b00;
        mem_fwd = 32'h20; wb_fwd = 32'h40;
        repeat (2) @(negedge clk);
        check_zero("reset_init");
        rst = 1'b0;

        //     name           frz cmd  s im ctl   rn            rm            so      s1 s2 dst   alu           rm            st    ctl   dst
        issue("add_ovf",      0, 4'h2, 1, 0, 3'b100, 32'h7FFFFFFF, 32'h1,     12'h000, 0, 0, 4'h1, 32'h80000000, 32'h1,        4'h9, 3'b100, 4'h1);
        issue("add_carry",    0, 4'h2, 1, 0, 3'b100, 32'hFFFFFFFF, 32'h1,     12'h000, 0, 0, 4'h2, 32'h0,        32'h1,        4'h6, 3'b100, 4'h2);
        issue("sub_eq",       0, 4'h4, 1, 0, 3'b100, 32'h5,        32'h5,     12'h000, 0, 0, 4'h3, 32'h0,        32'h5,        4'h6, 3'b100, 4'h3);
        issue("sbc_c1",       0, 4'h5, 1, 0, 3'b100, 32'h7,        32'h2,     12'h000, 0, 0, 4'h4, 32'h5,        32'h2,        4'h2, 3'b100, 4'h4);
        issue("add_clr_c",    0, 4'h2, 1, 0, 3'b100, 32'h1,        32'h1,     12'h000, 0, 0, 4'h5, 32'h2,        32'h1,        4'h0, 3'b100, 4'h5);
        issue("sbc_c0",       0, 4'h5, 1, 0, 3'b100, 32'h7,        32'h2,     12'h000, 0, 0, 4'h6, 32'h4,        32'h2,        4'h2, 3'b100, 4'h6);
        issue("adc_c1",       0, 4'h3, 0, 0, 3'b100, 32'h1,        32'h1,     12'h000, 0, 0, 4'h7, 32'h3,        32'h1,        4'h2, 3'b100, 4'h7);
        issue("imm_rot",      0, 4'h1, 0, 1, 3'b100, 32'h0,        32'hAAAA,  12'h4FF, 0, 0, 4'h8, 32'hFF000000, 32'hAAAA,     4'h2, 3'b100, 4'h8);
        issue("asr4_neg",     0, 4'h1, 1, 0, 3'b100, 32'h0,        32'h80000000, 12'h240, 0, 0, 4'h9, 32'hF8000000, 32'h80000000, 4'hA, 3'b100, 4'h9);
        issue("ldr_offset",   0, 4'h2, 0, 0, 3'b110, 32'h100,      32'h5,     12'h00C, 0, 0, 4'hA, 32'h10C,      32'h5,        4'hA, 3'b110, 4'hA);
        issue("fwd_mem",      0, 4'h2, 0, 1, 3'b100, 32'h999,      32'h0,     12'h003, 1, 0, 4'hB, 32'h23,       32'h0,        4'hA, 3'b100, 4'hB);
        issue("fwd_wb_ror0",  0, 4'h1, 0, 0, 3'b100, 32'h0,        32'h12345, 12'h060, 0, 2, 4'hC, 32'h40,       32'h40,       4'hA, 3'b100, 4'hC);
        issue("freeze_1",     1, 4'h2, 1, 0, 3'b001, 32'h1,        32'h7,     12'h001, 0, 0, 4'h5, 32'h40,       32'h40,       4'hA, 3'b100, 4'hC);
        issue("freeze_2",     1, 4'h4, 1, 0, 3'b010, 32'h2,        32'h8,     12'h002, 1, 1, 4'h6, 32'h40,       32'h40,       4'hA, 3'b100, 4'hC);
        issue("freeze_3",     1, 4'h9, 1, 0, 3'b000, 32'h3,        32'h9,     12'h003, 2, 2, 4'h7, 32'h40,       32'h40,       4'hA, 3'b100, 4'hC);
        issue("release_eor",  0, 4'h8, 1, 0, 3'b100, 32'hF0F0,     32'hFFFF,  12'h000, 0, 0, 4'hD, 32'h0F0F,     32'hFFFF,     4'h2, 3'b100, 4'hD);
        issue("bad_cmd",      0, 4'hF, 1, 0, 3'b100, 32'h3,        32'h3,     12'h000, 0, 0, 4'hE, 32'h0,        32'h3,        4'h6, 3'b100, 4'hE);
        issue("mvn",          0, 4'h9, 1, 0, 3'b100, 32'h0,        32'h0,     12'h000, 0, 0, 4'hF, 32'hFFFFFFFF, 32'h0,        4'hA, 3'b100, 4'hF);
        issue("sub_ovf",      0, 4'h4, 1, 0, 3'b100, 32'h80000000, 32'h1,     12'h000, 0, 0, 4'h1, 32'h7FFFFFFF, 32'h1,        4'h3, 3'b100, 4'h1);
        issue("lsr31",        0, 4'h1, 0, 0, 3'b100, 32'h0,        32'h80000000, 12'hFA0, 0, 0, 4'h2, 32'h1,     32'h80000000, 4'h3, 3'b100, 4'h2);
        issue("ror8",         0, 4'h1, 0, 0, 3'b100, 32'h0,        32'h12345678, 12'h460, 0, 0, 4'h3, 32'h78123456, 32'h12345678, 4'h3, 3'b100, 4'h3);
        issue("tst_zero",     0, 4'h6, 1, 0, 3'b000, 32'hF0F0,     32'h0F0F,  12'h000, 0, 0, 4'h4, 32'h0,        32'h0F0F,     4'h7, 3'b000, 4'h4);
        issue("orr",          0, 4'h7, 0, 0, 3'b100, 32'hF000,     32'h000F,  12'h000, 0, 0, 4'h5, 32'hF00F,     32'h000F,     4'h7, 3'b100, 4'h5);

        // Combinational outputs in the same cycle as the inputs.
        @(negedge clk);
        freeze = 1'b1; b_in = 1'b1; pc_in = 32'h100; signed_imm_24 = 24'hFFFFFE;
        wb_en_in = 1'b1; dest_in = 4'h9;
        #1;
        n_vec++;
        if (branch_taken !== 1'b1 || branch_address !== 32'hF8) begin
            n_err++;
            $display("FAIL branch: got taken=%b addr=%h, want taken=1 addr=000000f8",
                     branch_taken, branch_address);
        end
        n_vec++;
        if (wb_en_hazard !== 1'b1 || dest_hazard !== 4'h9) begin
            n_err++;
            $display("FAIL hazard: got wb=%b dest=%h, want wb=1 dest=9", wb_en_hazard, dest_hazard);
        end
        pc_in = 32'h1000; signed_imm_24 = 24'h000004; b_in = 1'b0;
        #1;
        n_vec++;
        if (branch_taken !== 1'b0 || branch_address !== 32'h1010) begin
            n_err++;
            $display("FAIL branch_fwd: got taken=%b addr=%h, want taken=0 addr=00001010",
                     branch_taken, branch_address);
        end

        repeat (2) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        // Asynchronous reset in the middle of a stall.
        #2 rst = 1'b1;
        #1 check_zero("reset_mid_stall");
        @(posedge clk);
        #1 check_zero("reset_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/exe_stage_module.md
# exe_stage_module

Execute stage of the five-stage ARM pipeline, directly upstream of the memory stage. It selects forwarded operands, generates the second operand (immediate rotate, register shift, or memory offset), runs the ALU, and maintains the NZCV status register. It computes the branch target and latches the results into the EXE/MEM pipeline register, which holds whenever the memory stage stalls.

## Interface
- REGISTER_LEN, 32, datapath width
- REG_ADDRESS_LEN, 4, register-file address width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  stall from memory stage (= !ready); holds pipeline register and status register
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control from ID/EXE
- s_in  in  1  update status flags; b_in  in  1  branch instruction
- imm  in  1  operand 2 is immediate
- exe_cmd  in  4  ALU op: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; other codes produce result 0
- pc_in  in  REGISTER_LEN  address of the following instruction (PC+4)
- val_Rn, val_Rm  in  REGISTER_LEN  register operands
- shift_operand  in  12; signed_imm_24  in  24
- dest_in  in  REG_ADDRESS_LEN
- sel_src1, sel_src2  in  2  forwarding select: 00 register, 01 mem_fwd, 10 wb_fwd, 11 register
- mem_fwd, wb_fwd  in  REGISTER_LEN  forwarded ALU result (EXE/MEM) and write-back value
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1  registered
- alu_res_out, val_Rm_out  out  REGISTER_LEN  registered (val_Rm_out is the forwarded Rm)
- dest_out  out  REG_ADDRESS_LEN  registered
- status_out  out  4  {N,Z,C,V}, registered
- branch_taken  out  1  combinational, = b_in
- branch_address  out  REGISTER_LEN  combinational, pc_in + (sign_extend(signed_imm_24) << 2)
- wb_en_hazard, dest_hazard  out  1 / REG_ADDRESS_LEN  combinational copies of wb_en_in and dest_in

## Operation
- val1 = the sel_src1 mux of val_Rn. Rm_f = the sel_src2 mux of val_Rm.
- val2 priority:
  - mem_r_en_in | mem_w_en_in: {20'b0, shift_operand}.
  - imm: {24'b0, shift_operand[7:0]} rotated right by 2·shift_operand[11:8].
  - Otherwise Rm_f shifted by shift_operand[11:7], type shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Rm_f unchanged.
- ALU arithmetic is 33-bit, and C = bit 32.
  - ADD: val1+val2.
  - ADC: val1+val2+C_reg.
  - SUB: val1−val2, with C = NOT borrow.
  - SBC: val1−val2−(1−C_reg).
- V is set on signed overflow. For ADD/ADC: operands have the same sign and the result sign differs. For SUB/SBC: operand signs differ and the result sign differs from val1.
- Logical ops, MOV and MVN (~val2) leave C and V unchanged.
- N = res[31]; Z = (res == 0).
- Status register: on clk, if s_in && !freeze, latch {N,Z,C,V}. Otherwise hold.
- Pipeline register: on clk, if !freeze, latch wb_en, mem_r_en, mem_w_en, ALU result, Rm_f and dest_in. Otherwise hold every field.
- CMP and TST are issued by decode as SUB/AND with wb_en_in=0 and s_in=1; this block needs no special case.

## Timing
- Reset, asynchronous and immediate: all registered outputs and status_out go to 0. Reset mid-stall also clears and overrides freeze.
- Latency: inputs appear on registered outputs one clock after capture. Combinational outputs follow inputs in the same cycle.
- While freeze=1, registered outputs and status_out are stable for the whole stall. The first edge after freeze falls captures the inputs present at that edge.
- ADC/SBC use C_reg as it was before the edge. Back-to-back flag-setting ops chain correctly.
- s_in with freeze=1: the flags are not updated, and the update happens on the edge where freeze=0.
- ROR #0 and a rotate_imm of 0 pass the value unchanged. ASR of a negative value fills with ones.

## Test plan
- Reset: rst=1 mid-cycle with freeze=1 → all registered outputs and status_out = 0 immediately.
- ADD with carry and overflow:
  - 0x7FFFFFFF + 1, s_in=1 → alu_res_out=0x80000000, status=1001.
  - 0xFFFFFFFF + 1 → 0x00000000, status=0110.
- SUB/SBC chain: SUB 5−5 → status 0110; then SBC 7−2 with C=1 → 5. With C=0 → 4.
- Operand 2 generation:
  - imm=1, shift_operand=0x4FF → val2=0xFF000000.
  - Register ASR #4 of 0x80000000 → 0xF8000000.
  - LDR with offset 0x00C, Rn=0x100 → alu_res_out=0x10C.
- Forwarding and freeze:
  - sel_src1=01, mem_fwd=0x20, ADD with val2=3 → 0x23.
  - Assert freeze for 3 cycles while the inputs change → outputs hold, then update one edge after release.
- Branch: pc_in=0x100, signed_imm_24=0xFFFFFE, b_in=1 → branch_taken=1, branch_address=0xF8 in the same cycle.
